ddr_capture_packer: RTL and testbench

- Parametrised next-generation dual-edge capture block.
- Samples a WIDTH-bit bus on both clock edges and presents a dual-edge mirror output.
- Also pairs each rising-edge sample with the following falling-edge sample, and packs DEPTH pairs into one wide word with a valid strobe.
- Sits at the boundary of DDR-style source-synchronous inputs, ahead of single-rate logic.

---
 rtl/ddr_capture_packer_pkg.sv | 14 +
 rtl/ddr_capture_packer_dual_edge_reg.sv | 36 +++
 rtl/ddr_capture_packer.sv | 97 +++++++++
 tb/tb_ddr_capture_packer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_capture_packer_pkg.sv
// Shared types and widths for the dual-edge capture packer.
// pair_t and CNT_W describe the default 4-bit, 4-deep build.
package ddr_pkg;

  localparam int DDR_WIDTH = 4;
  localparam int DDR_DEPTH = 4;
  localparam int CNT_W     = $clog2(DDR_DEPTH + 1);

  typedef struct packed {
    logic [DDR_WIDTH-1:0] fall;
    logic [DDR_WIDTH-1:0] rise;
  } pair_t;

endpackage

// File: rtl/ddr_capture_packer_dual_edge_reg.sv
// Captures d on both clock edges and mirrors the most recent capture on q_o.
// qp_o/qn_o expose the per-edge registers so the packer can form pairs.
module dual_edge_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] qp_o,
  output logic [WIDTH-1:0] qn_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] qp_q;
  logic [WIDTH-1:0] qn_q;

  // NOTE: non-blocking assignments keep every flop reading pre-edge values,
  // which is what lets the packer see the old qp at the next posedge.
  always_ff @(posedge clk) begin
    if (!resetn) qp_q <= '0;
    else         qp_q <= d_i;
  end

  // Reset is still sampled synchronously, just on the falling edge.
  always_ff @(negedge clk) begin
    if (!resetn) qn_q <= '0;
    else         qn_q <= d_i;
  end

  // High phase shows the posedge capture, low phase the negedge capture.
  always_comb q_o = clk ? qp_q : qn_q;

  assign qp_o = qp_q;
  assign qn_o = qn_q;

endmodule

// File: rtl/ddr_capture_packer.sv
// Dual-edge capture front end that pairs rise/fall samples and packs DEPTH
// pairs per output word, with flush support for partial words.
module ddr_capture_packer
  import ddr_pkg::*;
#(
  parameter int WIDTH = DDR_WIDTH,
  parameter int DEPTH = DDR_DEPTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [WIDTH-1:0]             d,
  input  logic                         en,
  input  logic                         flush,
  output logic [WIDTH-1:0]             q,
  output logic [2*WIDTH*DEPTH-1:0]     word_o,
  output logic [$clog2(DEPTH+1)-1:0]   word_pairs,
  output logic                         word_valid
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = 2 * WIDTH;
  localparam int WW = PW * DEPTH;

  logic [WIDTH-1:0] qp;
  logic [WIDTH-1:0] qn;

  dual_edge_reg #(.WIDTH(WIDTH)) u_edge (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (d),
    .qp_o   (qp),
    .qn_o   (qn),
    .q_o    (q)
  );

  logic          en_q;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [WW-1:0] pack_q,  pack_d;
  logic [WW-1:0] word_q,  word_d;
  logic [CW-1:0] pairs_q, pairs_d;
  logic          valid_q, valid_d;
  logic          emit;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which is what would infer a latch.
  always_comb begin
    pack_d  = pack_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    pairs_d = pairs_q;
    valid_d = 1'b0;

    // en_q marks that the pair begun at the previous posedge is now complete.
    if (en_q) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt_q == CW'(i)) pack_d[i*PW +: PW] = {qn, qp};
      end
      cnt_d = cnt_q + CW'(1);
    end

    emit = (en_q && (cnt_q == CW'(DEPTH - 1))) ||
           (flush && ((cnt_q != '0) || en_q));

    if (emit) begin
      word_d  = pack_d;
      pairs_d = cnt_d;
      valid_d = 1'b1;
      pack_d  = '0;
      cnt_d   = '0;
    end
  end

  // NOTE: the pack buffer is reset along with the control state, since its
  // zeroed slots are what a partial word presents as unfilled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q    <= 1'b0;
      cnt_q   <= '0;
      pack_q  <= '0;
      word_q  <= '0;
      pairs_q <= '0;
      valid_q <= 1'b0;
    end else begin
      en_q    <= en;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      word_q  <= word_d;
      pairs_q <= pairs_d;
      valid_q <= valid_d;
    end
  end

  assign word_o     = word_q;
  assign word_pairs = pairs_q;
  assign word_valid = valid_q;

endmodule

// File: tb/tb_ddr_capture_packer.sv
// Scoreboard bench for ddr_capture_packer (WIDTH=4, DEPTH=4): directed pair
// sequences, flush and reset corners, and a dual-edge mirror sweep on q.
module tb_ddr_capture_packer;
  import ddr_pkg::*;

  logic        clk;
  logic        resetn;
  logic [3:0]  d;
  logic        en;
  logic        flush;
  logic [3:0]  q;
  logic [31:0] word_o;
  logic [2:0]  word_pairs;
  logic        word_valid;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] word;
    logic [2:0]  pairs;
  } exp_t;

  exp_t sb[$];

  ddr_capture_packer #(.WIDTH(4), .DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .d          (d),
    .en         (en),
    .flush      (flush),
    .q          (q),
    .word_o     (word_o),
    .word_pairs (word_pairs),
    .word_valid (word_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a negedge: presents the rise sample with en/flush for
  // the coming posedge, then the fall sample for the following negedge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] f, input logic e, input logic fl);
    d     = r;
    en    = e;
    flush = fl;
    @(posedge clk);
    #1 d = f;
    @(negedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [31:0] w, input logic [2:0] p);
    exp_t e;
    e.word  = w;
    e.pairs = p;
    sb.push_back(e);
  endtask

  // Monitor: pops one expected word per valid strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {63'd0, word_valid}, 64'd0);
      end else begin
        exp_t  e;
        pair_t act_s;
        pair_t exp_s;
        e = sb.pop_front();
        check("word_o", {32'd0, word_o}, {32'd0, e.word});
        check("word_pairs", {61'd0, word_pairs}, {61'd0, e.pairs});
        for (int i = 0; i < 4; i++) begin
          act_s = word_o[i*8 +: 8];
          exp_s = e.word[i*8 +: 8];
          check($sformatf("slot%0d", i), {56'd0, act_s}, {56'd0, exp_s});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rv;
    resetn = 1'b0;
    d      = 4'h7;
    en     = 1'b1;
    flush  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_q", {60'd0, q}, 64'd0);
    check("rst_word_o", {32'd0, word_o}, 64'd0);
    check("rst_word_pairs", {61'd0, word_pairs}, 64'd0);
    check("rst_word_valid", {63'd0, word_valid}, 64'd0);
    resetn = 1'b1;
    en     = 1'b0;

    // Mirror: q follows the edge captures, not d between edges.
    for (int i = 0; i < 3; i++) begin
      d = 4'h3;
      @(posedge clk);
      #1 check("mirror_rise", {60'd0, q}, 64'h3);
      d = 4'hC;
      #1 check("mirror_hold", {60'd0, q}, 64'h3);
      @(negedge clk);
      #1 check("mirror_fall", {60'd0, q}, 64'hC);
    end

    // Full word of four pairs.
    cycle(4'h1, 4'hA, 1'b1, 1'b0);
    cycle(4'h2, 4'hB, 1'b1, 1'b0);
    cycle(4'h3, 4'hC, 1'b1, 1'b0);
    cycle(4'h4, 4'hD, 1'b1, 1'b0);
    expect_word(32'hD4C3B2A1, 3'd4);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // Partial word flushed after two pairs.
    cycle(4'h1, 4'hA, 1'b1, 1'b0);
    cycle(4'h2, 4'hB, 1'b1, 1'b0);
    expect_word(32'h0000B2A1, 3'd2);
    cycle(4'h0, 4'h0, 1'b0, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // Flush with nothing held: no word.
    cycle(4'h5, 4'h5, 1'b0, 1'b1);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // Flush coinciding with the fourth pair: a single full word.
    cycle(4'h1, 4'hA, 1'b1, 1'b0);
    cycle(4'h2, 4'hB, 1'b1, 1'b0);
    cycle(4'h3, 4'hC, 1'b1, 1'b0);
    cycle(4'h4, 4'hD, 1'b1, 1'b0);
    expect_word(32'hD4C3B2A1, 3'd4);
    cycle(4'h0, 4'h0, 1'b0, 1'b1);
    repeat (2) cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // en low mid-word: the partial word waits for more pairs.
    cycle(4'h1, 4'hA, 1'b1, 1'b0);
    cycle(4'h2, 4'hB, 1'b1, 1'b0);
    cycle(4'h7, 4'h7, 1'b0, 1'b0);
    cycle(4'h7, 4'h7, 1'b0, 1'b0);
    cycle(4'h3, 4'hC, 1'b1, 1'b0);
    cycle(4'h4, 4'hD, 1'b1, 1'b0);
    expect_word(32'hD4C3B2A1, 3'd4);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // Reset mid-word with en held high: partial word is dropped.
    cycle(4'h1, 4'hA, 1'b1, 1'b0);
    cycle(4'h2, 4'hB, 1'b1, 1'b0);
    cycle(4'h3, 4'hC, 1'b1, 1'b0);
    cycle(4'h9, 4'h9, 1'b0, 1'b0);
    d      = 4'h5;
    en     = 1'b1;
    resetn = 1'b0;
    @(posedge clk);
    #1 check("q_rst_rise", {60'd0, q}, 64'd0);
    d = 4'h9;
    @(negedge clk);
    #1 check("q_rst_fall", {60'd0, q}, 64'd0);
    resetn = 1'b1;
    cycle(4'h5, 4'hE, 1'b1, 1'b0);
    cycle(4'h6, 4'hF, 1'b1, 1'b0);
    cycle(4'h7, 4'h0, 1'b1, 1'b0);
    cycle(4'h8, 4'h1, 1'b1, 1'b0);
    expect_word(32'h1807F6E5, 3'd4);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0, 1'b0);

    // Mirror sweep: after each edge q must equal d as presented at that edge.
    for (int i = 0; i < 100; i++) begin
      rv = 4'($urandom_range(0, 15));
      d  = rv;
      @(posedge clk);
      #1 check("rand_rise", {60'd0, q}, {60'd0, rv});
      rv = 4'($urandom_range(0, 15));
      d  = rv;
      @(negedge clk);
      #1 check("rand_fall", {60'd0, q}, {60'd0, rv});
    end

    repeat (3) cycle(4'h0, 4'h0, 1'b0, 1'b0);
    check("pending_words", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
